// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared types and helpers for the rf_riscv_mp register file slice.
//   rf_state_e      : clear-engine state (RF_CLEAR while the array is being
//                     zeroed, RF_READY once it holds valid data)
//   RF_DEFAULT_*    : default geometry of the integer register file
//   rfSliceLo()     : low bit offset of port k inside a packed port bus
// ---------------------------------------------------------------------------
package rf_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    localparam int RF_DEFAULT_DATA_W   = 32;
    localparam int RF_DEFAULT_DEPTH    = 32;
    localparam int RF_DEFAULT_NUM_READ = 2;

    // Packed multi-port buses place port k at [k*width +: width].
    function automatic int rfSliceLo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/rf_clear_fsm.sv
// ---------------------------------------------------------------------------
// rf_clear_fsm
// Sequential clear engine for the register file. After reset, or when
// clear_i is seen, it walks the array one address per clock and emits a
// zero-write strobe for each. ready_o goes high once the last address has
// been written.
//   clk_i        in   clock
//   rst_ni       in   asynchronous active-low reset
//   clear_i      in   request (or restart) of a full sweep
//   ready_o      out  1 = array valid, 0 = sweep in progress
//   clearWe_o    out  zero-write strobe for the array
//   clearAddr_o  out  address being zeroed
// ---------------------------------------------------------------------------
module rf_clear_fsm
    import rf_pkg::*;
#(
    parameter  int DEPTH    = RF_DEFAULT_DEPTH,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    output logic              ready_o,
    output logic              clearWe_o,
    output logic [ADDR_W-1:0] clearAddr_o
);

    // When register 0 is hardwired it never needs clearing, so the sweep
    // starts one address higher.
    localparam logic [ADDR_W-1:0] FIRST = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // State register and sweep pointer. Reset drops straight back into a
    // fresh sweep, so stale array contents are never exposed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RF_CLEAR;
            cnt_q   <= FIRST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. A clear request always rewinds the pointer and
    // suppresses the zero-write on that edge. The pointer parks on the last
    // address instead of wrapping when the sweep finishes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clearWe_o   = 1'b0;
        clearAddr_o = cnt_q;
        case (state_q)
            RF_CLEAR: begin
                if (clear_i) begin
                    cnt_d = FIRST;
                end else begin
                    clearWe_o = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = RF_READY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RF_READY: begin
                if (clear_i) begin
                    state_d = RF_CLEAR;
                    cnt_d   = FIRST;
                end
            end
            default: begin
                state_d = RF_CLEAR;
                cnt_d   = FIRST;
            end
        endcase
    end

    assign ready_o = (state_q == RF_READY);

endmodule

// File: rtl/rf_riscv_mp.sv
// ---------------------------------------------------------------------------
// rf_riscv_mp
// Parametrised multi-port integer register file for the decode stage.
// One synchronous write port (from write-back), NUM_READ combinational read
// ports (to the operand muxes), optional hardwired-zero x0, and a clear
// engine that zeroes the array after reset or on request.
//   clk_i           in   clock
//   rst_ni          in   asynchronous active-low reset
//   clear_i         in   request to zero the whole array
//   ready_o         out  1 = array valid and writes accepted
//   write_enable_i  in   write strobe (ignored while clearing)
//   write_addr_i    in   write address
//   write_data_i    in   write data
//   read_addr_i     in   packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   read_data_o     out  packed read data, port k at [k*DATA_W +: DATA_W]
// Build option: define RF_BYPASS_EN to forward same-cycle write data to
// read ports addressing the register being written.
// ---------------------------------------------------------------------------
module rf_riscv_mp
    import rf_pkg::*;
#(
    parameter  int DATA_W   = RF_DEFAULT_DATA_W,
    parameter  int DEPTH    = RF_DEFAULT_DEPTH,
    parameter  int NUM_READ = RF_DEFAULT_NUM_READ,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    output logic                       ready_o,
    input  logic                       write_enable_i,
    input  logic [ADDR_W-1:0]          write_addr_i,
    input  logic [DATA_W-1:0]          write_data_i,
    input  logic [NUM_READ*ADDR_W-1:0] read_addr_i,
    output logic [NUM_READ*DATA_W-1:0] read_data_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic              clearWe;
    logic [ADDR_W-1:0] clearAddr;
    logic              userWe;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memData;

    rf_clear_fsm #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) uClearFsm (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .ready_o     (ready),
        .clearWe_o   (clearWe),
        .clearAddr_o (clearAddr)
    );

    assign ready_o = ready;

    // A user write only lands when the array is valid; writes to a
    // hardwired x0 are dropped here so the bypass path also ignores them.
    always_comb begin
        userWe = ready && write_enable_i &&
                 !((ZERO_REG != 0) && (write_addr_i == '0));
    end

    // Single array write port shared by the clear engine and write-back.
    // The two never collide: the engine only writes while not ready.
    always_comb begin
        memWe   = clearWe | userWe;
        memAddr = write_addr_i;
        memData = write_data_i;
        if (clearWe) begin
            memAddr = clearAddr;
            memData = '0;
        end
    end

    // The storage itself carries no reset; the clear engine zeroes it.
    always_ff @(posedge clk_i) begin
        if (memWe) begin
            mem[memAddr] <= memData;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : gRead
        localparam int ALO = rfSliceLo(k, ADDR_W);
        localparam int DLO = rfSliceLo(k, DATA_W);

        logic [ADDR_W-1:0] rAddr;
        logic [DATA_W-1:0] rData;

        assign rAddr = read_addr_i[ALO +: ADDR_W];

        // Independent read mux per port. The zero rules are applied last so
        // they override both stored data and any forwarded write data.
        always_comb begin
            rData = mem[rAddr];
`ifdef RF_BYPASS_EN
            if (userWe && (rAddr == write_addr_i)) begin
                rData = write_data_i;
            end
`endif
            if (!ready || ((ZERO_REG != 0) && (rAddr == '0))) begin
                rData = '0;
            end
        end

        assign read_data_o[DLO +: DATA_W] = rData;
    end

endmodule

// File: tb/tb_rf_riscv_mp.sv
// ---------------------------------------------------------------------------
// tb_rf_riscv_mp
// Self-checking bench for rf_riscv_mp. Two instances: the default
// configuration (32x32, 2 ports, x0 hardwired) and a wide one
// (16x64, 4 ports, x0 ordinary storage). Expected values go into a queue
// when stimulus is driven and are popped when the outputs are sampled.
// ---------------------------------------------------------------------------
module tb_rf_riscv_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clear;
    logic        ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;

    logic         clear4;
    logic         ready4;
    logic         we4;
    logic [3:0]   waddr4;
    logic [63:0]  wdata4;
    logic [15:0]  raddr4;
    logic [255:0] rdata4;

    rf_riscv_mp #(
        .DATA_W   (32),
        .DEPTH    (32),
        .NUM_READ (2),
        .ZERO_REG (1)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .ready_o        (ready),
        .write_enable_i (we),
        .write_addr_i   (waddr),
        .write_data_i   (wdata),
        .read_addr_i    (raddr),
        .read_data_o    (rdata)
    );

    rf_riscv_mp #(
        .DATA_W   (64),
        .DEPTH    (16),
        .NUM_READ (4),
        .ZERO_REG (0)
    ) dut4 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear4),
        .ready_o        (ready4),
        .write_enable_i (we4),
        .write_addr_i   (waddr4),
        .write_data_i   (wdata4),
        .read_addr_i    (raddr4),
        .read_data_o    (rdata4)
    );

    int checks   = 0;
    int failures = 0;
    logic [63:0] expQ[$];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs[8];

    int r1;
    int r4;
    int n;
    logic [63:0] v4[4];
    logic [3:0]  a4[4];

    // Record what the DUT should produce for the stimulus just driven.
    task automatic expectVal(input logic [63:0] v);
        expQ.push_back(v);
    endtask

    // Pop the oldest expectation and compare it against an observed value.
    task automatic checkOutput(input string name, input logic [63:0] act);
        logic [63:0] e;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL %s: no expected value queued, actual=%h", name, act);
        end else begin
            e = expQ.pop_front();
            if (act !== e) begin
                failures++;
                $display("[TB] FAIL %s: actual=%h expected=%h", name, act, e);
            end
        end
    endtask

    // Drive one table vector on the default instance and check both ports
    // combinationally before the next rising edge commits the write.
    task automatic applyStimulus(input int idx);
        @(negedge clk);
        we    = vecs[idx].we;
        waddr = vecs[idx].wa;
        wdata = vecs[idx].wd;
        raddr = {vecs[idx].ra1, vecs[idx].ra0};
        expectVal({32'd0, vecs[idx].exp0});
        expectVal({32'd0, vecs[idx].exp1});
        #1;
        checkOutput($sformatf("vec%0d_port0", idx), {32'd0, rdata[31:0]});
        checkOutput($sformatf("vec%0d_port1", idx), {32'd0, rdata[63:32]});
    endtask

    // Count rising edges until the default instance reports ready. The
    // caller leaves clear at the value wanted for the first edge; it is
    // dropped after that edge. Optionally probe port0 mid-sweep.
    task automatic waitReady(input bit probe, output int cnt);
        cnt = -1;
        if (probe) expectVal(64'd0);
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk);
            #1;
            clear = 1'b0;
            if (probe && e == 5) checkOutput("sweep_read_zero", {32'd0, rdata[31:0]});
            if (ready) begin
                cnt = e;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        clear  = 1'b0;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr  = '0;
        clear4 = 1'b0;
        we4    = 1'b0;
        waddr4 = '0;
        wdata4 = '0;
        raddr4 = '0;

        vecs[0] = '{1'b1, 5'd7,  32'h12345678, 5'd1,  5'd2,  32'h0,        32'h0};
        vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd7,  5'd0,  32'h12345678, 32'h0};
        vecs[2] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  32'h0,        32'h12345678};
        vecs[3] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd5,  5'd7,  32'h0,        32'h12345678};
        vecs[4] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 5'd1,  32'h00000001, 5'd31, 5'd0,  32'hCAFEF00D, 32'h0};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd7,  32'h00000001, 32'h12345678};
        vecs[7] = '{1'b1, 5'd0,  32'h12121212, 5'd0,  5'd0,  32'h0,        32'h0};

        // Reset values on both instances.
        @(negedge clk);
        raddr  = {5'd7, 5'd5};
        raddr4 = {4'd3, 4'd2, 4'd1, 4'd0};
        expectVal(64'd0);
        expectVal(64'd0);
        expectVal(64'd0);
        expectVal(64'd0);
        expectVal(64'd0);
        expectVal(64'd0);
        #1;
        checkOutput("reset_ready",       {63'd0, ready});
        checkOutput("reset_ready4",      {63'd0, ready4});
        checkOutput("reset_read_port0",  {32'd0, rdata[31:0]});
        checkOutput("reset_read_port1",  {32'd0, rdata[63:32]});
        checkOutput("reset_read4_port0", rdata4[63:0]);
        checkOutput("reset_read4_port3", rdata4[255:192]);

        // Release reset while write-back hammers x5; those writes must be lost.
        rst_n = 1'b1;
        r1 = 0;
        r4 = 0;
        expectVal(64'd0);
        for (int e = 1; e <= 100; e++) begin
            we     = (e <= 20);
            waddr  = 5'd5;
            wdata  = 32'hDEADBEEF;
            we4    = (e <= 8);
            waddr4 = 4'd5;
            wdata4 = '1;
            @(posedge clk);
            #1;
            if (e == 5) checkOutput("clear_write_masked", {32'd0, rdata[31:0]});
            if (ready  && r1 == 0) r1 = e;
            if (ready4 && r4 == 0) r4 = e;
            if (r1 != 0 && r4 != 0) break;
        end
        we  = 1'b0;
        we4 = 1'b0;
        expectVal(64'd31);
        checkOutput("reset_sweep_edges", 64'(r1));
        expectVal(64'd16);
        checkOutput("reset_sweep_edges4", 64'(r4));

        for (int i = 0; i < 8; i++) applyStimulus(i);

        // Same-cycle read of the register being written.
        @(negedge clk);
        we    = 1'b1;
        waddr = 5'd3;
        wdata = 32'hA5A5A5A5;
        raddr = {5'd3, 5'd3};
`ifdef RF_BYPASS_EN
        expectVal(64'hA5A5A5A5);
        expectVal(64'hA5A5A5A5);
`else
        expectVal(64'd0);
        expectVal(64'd0);
`endif
        #1;
        checkOutput("raw_same_cycle_port0", {32'd0, rdata[31:0]});
        checkOutput("raw_same_cycle_port1", {32'd0, rdata[63:32]});
        @(negedge clk);
        we = 1'b0;
        expectVal(64'hA5A5A5A5);
        expectVal(64'hA5A5A5A5);
        #1;
        checkOutput("raw_after_edge_port0", {32'd0, rdata[31:0]});
        checkOutput("raw_after_edge_port1", {32'd0, rdata[63:32]});

        // Wide four-port instance: distinct and identical addresses.
        v4[0] = 64'h0123456789ABCDEF; a4[0] = 4'd0;
        v4[1] = 64'hFEDCBA9876543210; a4[1] = 4'd3;
        v4[2] = 64'hDEADBEEFCAFEBABE; a4[2] = 4'd9;
        v4[3] = 64'hFFFF0000FFFF0000; a4[3] = 4'd15;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            we4    = 1'b1;
            waddr4 = a4[i];
            wdata4 = v4[i];
        end
        @(negedge clk);
        we4    = 1'b0;
        raddr4 = {a4[3], a4[2], a4[1], a4[0]};
        for (int k = 0; k < 4; k++) expectVal(v4[k]);
        #1;
        for (int k = 0; k < 4; k++) checkOutput($sformatf("wide_distinct_port%0d", k), rdata4[k*64 +: 64]);
        @(negedge clk);
        raddr4 = {4'd9, 4'd9, 4'd9, 4'd9};
        for (int k = 0; k < 4; k++) expectVal(v4[2]);
        #1;
        for (int k = 0; k < 4; k++) checkOutput($sformatf("wide_same_port%0d", k), rdata4[k*64 +: 64]);
        @(negedge clk);
        raddr4 = {4'd9, 4'd9, 4'd9, 4'd5};
        expectVal(64'd0);
        for (int k = 1; k < 4; k++) expectVal(v4[2]);
        #1;
        for (int k = 0; k < 4; k++) checkOutput($sformatf("wide_mixed_port%0d", k), rdata4[k*64 +: 64]);

        // Fill every register with its index, then clear the array.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            we    = 1'b1;
            waddr = 5'(i);
            wdata = 32'(i);
        end
        @(negedge clk);
        we    = 1'b0;
        raddr = {5'd31, 5'd17};
        expectVal(64'd17);
        expectVal(64'd31);
        #1;
        checkOutput("fill_port0", {32'd0, rdata[31:0]});
        checkOutput("fill_port1", {32'd0, rdata[63:32]});

        @(negedge clk);
        raddr = {5'd0, 5'd9};
        clear = 1'b1;
        waitReady(1'b1, n);
        expectVal(64'd32);
        checkOutput("clear_sweep_edges", 64'(n));
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            raddr = {5'(2 * i + 1), 5'(2 * i)};
            expectVal(64'd0);
            expectVal(64'd0);
            #1;
            checkOutput($sformatf("post_clear_x%0d", 2 * i),     {32'd0, rdata[31:0]});
            checkOutput($sformatf("post_clear_x%0d", 2 * i + 1), {32'd0, rdata[63:32]});
        end

        // Restart the sweep with clear_i on its tenth edge.
        @(negedge clk);
        clear = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            clear = 1'b0;
        end
        clear = 1'b1;
        waitReady(1'b0, n);
        expectVal(64'd32);
        checkOutput("restart_sweep_edges", 64'(n));

        // Asynchronous reset from READY, then again mid-sweep.
        @(negedge clk);
        we    = 1'b1;
        waddr = 5'd4;
        wdata = 32'h00000044;
        @(negedge clk);
        we    = 1'b0;
        raddr = {5'd0, 5'd4};
        expectVal(64'h44);
        #1;
        checkOutput("pre_reset_read", {32'd0, rdata[31:0]});
        rst_n = 1'b0;
        expectVal(64'd0);
        expectVal(64'd0);
        #1;
        checkOutput("async_reset_ready", {63'd0, ready});
        checkOutput("async_reset_read",  {32'd0, rdata[31:0]});
        @(negedge clk);
        rst_n = 1'b1;
        waitReady(1'b0, n);
        expectVal(64'd31);
        checkOutput("reset_release_edges", 64'(n));

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        expectVal(64'd0);
        #1;
        checkOutput("midsweep_reset_ready", {63'd0, ready});
        @(negedge clk);
        rst_n = 1'b1;
        waitReady(1'b0, n);
        expectVal(64'd31);
        checkOutput("midsweep_reset_edges", 64'(n));
        @(negedge clk);
        raddr = {5'd0, 5'd4};
        expectVal(64'd0);
        #1;
        checkOutput("post_reset_x4", {32'd0, rdata[31:0]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
